// File: rtl/gb_bootbus_ctrl.sv
// gb_bootbus_ctrl
// Bus sequencer between the CPU / OAM-DMA requesters and the boot ROM plus
// cartridge bus. It arbitrates in IDLE, decodes the granted access to the
// boot ROM, the hide register or the external bus, and runs a fixed
// SETUP -> STROBE -> [WAIT] -> DONE sequence. It returns read data with a
// one-cycle ack.
//
// Ports
//   clk, reset            system clock, async active-high reset
//   cpu_req/we/adr/dout   CPU request (level, held until cpu_ack)
//   cpu_din, cpu_ack      CPU read data and completion pulse
//   dma_req/adr           DMA read request (level, held until dma_ack)
//   dma_din, dma_ack      DMA read data and completion pulse
//   rom_adr, rom_read     boot ROM address and edge-sensitive read strobe
//   rom_write_reg         hide-register write pulse
//   rom_dout, rom_hide    boot ROM data, 1 = boot ROM unmapped
//   ext_adr/dout/rd/wr    cartridge address, write data, strobes
//   ext_din               cartridge read data
//
// state  | meaning
// IDLE   | waiting for a request; arbitration and decode happen here
// SETUP  | address/data outputs settled, no strobe
// STROBE | first strobe cycle (rom_read, rom_write_reg, ext_rd or ext_wr)
// WAIT   | extra external strobe cycles, wait_cnt counts down to 0
// DONE   | strobes low, ack to the granted requester for one cycle
module gb_bootbus_ctrl #(
    parameter int          EXT_WAIT = 1,
    parameter logic [15:0] HIDE_ADR = 16'hFF50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_adr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic [15:0] dma_adr,
    output logic [7:0]  dma_din,
    output logic        dma_ack,
    output logic [7:0]  rom_adr,
    output logic        rom_read,
    output logic        rom_write_reg,
    input  logic [7:0]  rom_dout,
    input  logic        rom_hide,
    output logic [15:0] ext_adr,
    output logic [7:0]  ext_dout,
    output logic        ext_rd,
    output logic        ext_wr,
    input  logic [7:0]  ext_din
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_ROM,
        K_REG,
        K_EXT
    } kind_t;

    localparam bit         HAS_WAIT  = (EXT_WAIT != 0);
    localparam logic [2:0] WAIT_LOAD = HAS_WAIT ? 3'(EXT_WAIT - 1) : 3'd0;

    state_t     state;
    kind_t      kind_q;
    logic       we_q;
    logic       owner_dma;
    logic       last_dma;
    logic [2:0] wait_cnt;

    logic        grant_dma;
    logic        grant_cpu;
    logic        sel_we;
    logic [15:0] sel_adr;
    kind_t       sel_kind;
    logic        last_strobe;
    logic [7:0]  rd_data;

    // Round-robin only matters when both request; last_dma resets to 1 so the
    // CPU wins the first contested grant.
    always_comb begin
        grant_dma = dma_req && (!cpu_req || !last_dma);
        grant_cpu = cpu_req && !grant_dma;
        sel_adr   = grant_dma ? dma_adr : cpu_adr;
        sel_we    = grant_dma ? 1'b0 : cpu_we;
        if (sel_adr == HIDE_ADR)
            sel_kind = K_REG;
        else if (!sel_we && (sel_adr[15:8] == 8'h00) && !rom_hide)
            sel_kind = K_ROM;
        else
            sel_kind = K_EXT;
    end

    // The edge that ends the last strobe cycle samples the read data.
    always_comb begin
        last_strobe = 1'b0;
        if (state == ST_STROBE)
            last_strobe = !((kind_q == K_EXT) && HAS_WAIT);
        else if (state == ST_WAIT)
            last_strobe = (wait_cnt == 3'd0);
        case (kind_q)
            K_ROM:   rd_data = rom_dout;
            K_EXT:   rd_data = ext_din;
            default: rd_data = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            kind_q        <= K_EXT;
            we_q          <= 1'b0;
            owner_dma     <= 1'b0;
            last_dma      <= 1'b1;
            wait_cnt      <= 3'd0;
            cpu_din       <= 8'hFF;
            cpu_ack       <= 1'b0;
            dma_din       <= 8'hFF;
            dma_ack       <= 1'b0;
            rom_adr       <= 8'h00;
            rom_read      <= 1'b0;
            rom_write_reg <= 1'b0;
            ext_adr       <= 16'h0000;
            ext_dout      <= 8'h00;
            ext_rd        <= 1'b0;
            ext_wr        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req || dma_req) begin
                        state     <= ST_SETUP;
                        last_dma  <= grant_dma;
                        owner_dma <= grant_dma;
                        kind_q    <= sel_kind;
                        we_q      <= sel_we;
                        rom_adr   <= sel_adr[7:0];
                        ext_adr   <= sel_adr;
                        if (grant_cpu && cpu_we)
                            ext_dout <= cpu_dout;
                    end
                end
                ST_SETUP: begin
                    state <= ST_STROBE;
                    case (kind_q)
                        K_ROM: rom_read <= 1'b1;
                        K_REG: rom_write_reg <= we_q;
                        default: begin
                            ext_rd <= !we_q;
                            ext_wr <= we_q;
                        end
                    endcase
                end
                ST_STROBE: begin
                    if ((kind_q == K_EXT) && HAS_WAIT) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 3'd0)
                        state <= ST_DONE;
                    else
                        wait_cnt <= wait_cnt - 3'd1;
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase

            if (last_strobe) begin
                rom_read      <= 1'b0;
                rom_write_reg <= 1'b0;
                ext_rd        <= 1'b0;
                ext_wr        <= 1'b0;
                cpu_ack       <= !owner_dma;
                dma_ack       <= owner_dma;
                // Writes return nothing, so the din registers keep their value.
                if (!we_q) begin
                    if (owner_dma)
                        dma_din <= rd_data;
                    else
                        cpu_din <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_gb_bootbus_ctrl.sv
module tb_gb_bootbus_ctrl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_dout, cpu_din;
    logic        cpu_ack;
    logic        dma_req;
    logic [15:0] dma_adr;
    logic [7:0]  dma_din;
    logic        dma_ack;
    logic [7:0]  rom_adr;
    logic        rom_read, rom_write_reg;
    logic [7:0]  rom_dout;
    logic        rom_hide;
    logic [15:0] ext_adr;
    logic [7:0]  ext_dout;
    logic        ext_rd, ext_wr;
    logic [7:0]  ext_din;

    gb_bootbus_ctrl #(.EXT_WAIT(W), .HIDE_ADR(16'hFF50)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_adr(dma_adr), .dma_din(dma_din), .dma_ack(dma_ack),
        .rom_adr(rom_adr), .rom_read(rom_read), .rom_write_reg(rom_write_reg),
        .rom_dout(rom_dout), .rom_hide(rom_hide),
        .ext_adr(ext_adr), .ext_dout(ext_dout), .ext_rd(ext_rd), .ext_wr(ext_wr),
        .ext_din(ext_din)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_val(input logic [7:0] a);
        return 8'(a * 8'd7 + 8'd14);
    endfunction

    assign rom_dout = rom_val(rom_adr);

    typedef struct packed {
        logic       dma;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int n_rom_rd = 0, n_ext_rd = 0, n_ext_wr = 0, n_wreg = 0;
    int n_cpu_ack = 0, n_overlap = 0;
    int rise_rom_rd = -1, rise_ext_rd = -1, rise_ext_wr = -1, rise_wreg = -1;
    logic p_rom_rd = 0, p_ext_rd = 0, p_ext_wr = 0, p_wreg = 0;
    logic [7:0] ext_wr_dout = 8'h00;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rom_read) begin n_rom_rd++; if (!p_rom_rd) rise_rom_rd = cyc; end
        if (ext_rd) begin n_ext_rd++; if (!p_ext_rd) rise_ext_rd = cyc; end
        if (ext_wr) begin n_ext_wr++; if (!p_ext_wr) rise_ext_wr = cyc; ext_wr_dout = ext_dout; end
        if (rom_write_reg) begin n_wreg++; if (!p_wreg) rise_wreg = cyc; end
        if (cpu_ack) n_cpu_ack++;
        if ((rom_read && (ext_rd || ext_wr)) || (cpu_ack && dma_ack)) n_overlap++;
        p_rom_rd = rom_read;
        p_ext_rd = ext_rd;
        p_ext_wr = ext_wr;
        p_wreg   = rom_write_reg;
    end

    // Drives one request, waits (bounded) for its ack, then releases req.
    task automatic do_access(input logic is_dma, input logic we, input logic [15:0] adr,
                             input logic [7:0] wdata, output int g, output int ack_cyc,
                             output logic [7:0] din_obs, output logic got);
        @(posedge clk); #1;
        if (is_dma) begin
            dma_req = 1'b1; dma_adr = adr;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_dout = wdata;
        end
        g = cyc; got = 1'b0; ack_cyc = -1; din_obs = 8'h00;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (is_dma ? dma_ack : cpu_ack) begin
                got = 1'b1; ack_cyc = cyc; din_obs = is_dma ? dma_din : cpu_din;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; dma_req = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (cpu_din !== 8'hFF) $display("FAIL rst_cpu_din: got %h want ff", cpu_din); else n_pass++;
        n_checks++; if (dma_din !== 8'hFF) $display("FAIL rst_dma_din: got %h want ff", dma_din); else n_pass++;
        n_checks++; if ({cpu_ack, dma_ack, rom_read, rom_write_reg, ext_rd, ext_wr} !== 6'b0)
            $display("FAIL rst_strobes: got %b want 000000", {cpu_ack, dma_ack, rom_read, rom_write_reg, ext_rd, ext_wr});
        else n_pass++;
        n_checks++; if ({rom_adr, ext_adr, ext_dout} !== 32'h0)
            $display("FAIL rst_adr: got %h want 0", {rom_adr, ext_adr, ext_dout}); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_rom_read;
        int g, a, r0, e0; logic [7:0] d; logic got; exp_t e;
        rom_hide = 1'b0;
        r0 = n_rom_rd; e0 = n_ext_rd;
        sb_q.push_back('{dma: 1'b0, data: rom_val(8'h05)});
        do_access(1'b0, 1'b0, 16'h0005, 8'h00, g, a, d, got);
        e = sb_q.pop_front();
        n_checks++; if (!got) $display("FAIL rom_rd_timeout: got no ack want ack");
        else if (d !== e.data) $display("FAIL rom_rd_data: got %h want %h", d, e.data); else n_pass++;
        n_checks++; if (a - g !== 3) $display("FAIL rom_rd_lat: got %0d want 3", a - g); else n_pass++;
        n_checks++; if (rom_adr !== 8'h05) $display("FAIL rom_rd_adr: got %h want 05", rom_adr); else n_pass++;
        n_checks++; if (n_rom_rd - r0 !== 1 || rise_rom_rd - g !== 2)
            $display("FAIL rom_rd_strobe: got cnt %0d at +%0d want 1 at +2", n_rom_rd - r0, rise_rom_rd - g);
        else n_pass++;
        n_checks++; if (n_ext_rd - e0 !== 0) $display("FAIL rom_rd_no_ext: got %0d want 0", n_ext_rd - e0); else n_pass++;
    endtask

    task automatic test_reg_write;
        int g, a, w0, x0, r0, e0; logic [7:0] d; logic got; exp_t e;
        w0 = n_wreg; x0 = n_ext_wr;
        do_access(1'b0, 1'b1, 16'hFF50, 8'h01, g, a, d, got);
        n_checks++; if (!got) $display("FAIL reg_wr_timeout: got no ack want ack");
        else if (a - g !== 3) $display("FAIL reg_wr_lat: got %0d want 3", a - g); else n_pass++;
        n_checks++; if (n_wreg - w0 !== 1 || rise_wreg - g !== 2)
            $display("FAIL reg_wr_pulse: got cnt %0d at +%0d want 1 at +2", n_wreg - w0, rise_wreg - g);
        else n_pass++;
        n_checks++; if (n_ext_wr - x0 !== 0) $display("FAIL reg_wr_no_ext: got %0d want 0", n_ext_wr - x0); else n_pass++;

        rom_hide = 1'b1; ext_din = 8'h5C;
        r0 = n_rom_rd; e0 = n_ext_rd;
        sb_q.push_back('{dma: 1'b0, data: 8'h5C});
        do_access(1'b0, 1'b0, 16'h0005, 8'h00, g, a, d, got);
        e = sb_q.pop_front();
        n_checks++; if (!got) $display("FAIL hidden_timeout: got no ack want ack");
        else if (d !== e.data) $display("FAIL hidden_data: got %h want %h", d, e.data); else n_pass++;
        n_checks++; if (ext_adr !== 16'h0005) $display("FAIL hidden_adr: got %h want 0005", ext_adr); else n_pass++;
        n_checks++; if (n_rom_rd - r0 !== 0 || n_ext_rd - e0 !== 1 + W)
            $display("FAIL hidden_strobes: got rom %0d ext %0d want 0 and %0d", n_rom_rd - r0, n_ext_rd - e0, 1 + W);
        else n_pass++;
        rom_hide = 1'b0;
    endtask

    task automatic test_ext;
        int g, a, e0, x0; logic [7:0] d; logic got; exp_t e;
        ext_din = 8'hA5; e0 = n_ext_rd;
        sb_q.push_back('{dma: 1'b0, data: 8'hA5});
        do_access(1'b0, 1'b0, 16'h4000, 8'h00, g, a, d, got);
        e = sb_q.pop_front();
        n_checks++; if (!got) $display("FAIL ext_rd_timeout: got no ack want ack");
        else if (d !== e.data) $display("FAIL ext_rd_data: got %h want %h", d, e.data); else n_pass++;
        n_checks++; if (a - g !== 3 + W) $display("FAIL ext_rd_lat: got %0d want %0d", a - g, 3 + W); else n_pass++;
        n_checks++; if (n_ext_rd - e0 !== 1 + W || rise_ext_rd - g !== 2)
            $display("FAIL ext_rd_strobe: got cnt %0d at +%0d want %0d at +2", n_ext_rd - e0, rise_ext_rd - g, 1 + W);
        else n_pass++;

        x0 = n_ext_wr;
        do_access(1'b0, 1'b1, 16'h2000, 8'h03, g, a, d, got);
        n_checks++; if (!got) $display("FAIL ext_wr_timeout: got no ack want ack");
        else if (a - g !== 3 + W) $display("FAIL ext_wr_lat: got %0d want %0d", a - g, 3 + W); else n_pass++;
        n_checks++; if (n_ext_wr - x0 !== 1 + W || rise_ext_wr - g !== 2)
            $display("FAIL ext_wr_strobe: got cnt %0d at +%0d want %0d at +2", n_ext_wr - x0, rise_ext_wr - g, 1 + W);
        else n_pass++;
        n_checks++; if (ext_wr_dout !== 8'h03 || ext_adr !== 16'h2000)
            $display("FAIL ext_wr_bus: got %h/%h want 03/2000", ext_wr_dout, ext_adr); else n_pass++;
    endtask

    task automatic test_dma;
        int g, a, r0, e0, w0; logic [7:0] d; logic got; exp_t e;
        rom_hide = 1'b0; r0 = n_rom_rd;
        sb_q.push_back('{dma: 1'b1, data: rom_val(8'h10)});
        do_access(1'b1, 1'b0, 16'h0010, 8'h00, g, a, d, got);
        e = sb_q.pop_front();
        n_checks++; if (!got) $display("FAIL dma_rom_timeout: got no ack want ack");
        else if (d !== e.data) $display("FAIL dma_rom_data: got %h want %h", d, e.data); else n_pass++;
        n_checks++; if (n_rom_rd - r0 !== 1 || a - g !== 3)
            $display("FAIL dma_rom_seq: got cnt %0d lat %0d want 1 and 3", n_rom_rd - r0, a - g); else n_pass++;

        r0 = n_rom_rd; e0 = n_ext_rd; w0 = n_wreg;
        sb_q.push_back('{dma: 1'b1, data: 8'hFF});
        do_access(1'b1, 1'b0, 16'hFF50, 8'h00, g, a, d, got);
        e = sb_q.pop_front();
        n_checks++; if (!got) $display("FAIL dma_reg_timeout: got no ack want ack");
        else if (d !== e.data) $display("FAIL dma_reg_data: got %h want %h", d, e.data); else n_pass++;
        n_checks++; if ((n_rom_rd - r0) + (n_ext_rd - e0) + (n_wreg - w0) !== 0 || a - g !== 3)
            $display("FAIL dma_reg_seq: got strobes %0d lat %0d want 0 and 3",
                     (n_rom_rd - r0) + (n_ext_rd - e0) + (n_wreg - w0), a - g);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int g, prev, acks; logic [7:0] last_dma; exp_t e;
        test_reset();
        rom_hide = 1'b0; last_dma = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{dma: 1'b0, data: rom_val(8'h03)});
            sb_q.push_back('{dma: 1'b1, data: rom_val(8'h10)});
        end
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0003;
        dma_req = 1'b1; dma_adr = 16'h0010;
        g = cyc; prev = g - 1; acks = 0;
        for (int i = 0; i < 60 && acks < 4; i++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) begin
                e = sb_q.pop_front();
                acks++;
                n_checks++; if (dma_ack !== e.dma || cpu_ack !== !e.dma)
                    $display("FAIL b2b_owner%0d: got cpu %b dma %b want dma %b", acks, cpu_ack, dma_ack, e.dma);
                else n_pass++;
                n_checks++; if ((e.dma ? dma_din : cpu_din) !== e.data)
                    $display("FAIL b2b_data%0d: got %h want %h", acks, e.dma ? dma_din : cpu_din, e.data);
                else n_pass++;
                n_checks++; if (cyc - prev !== (acks == 1 ? 4 : 4))
                    $display("FAIL b2b_spacing%0d: got %0d want 4", acks, cyc - prev); else n_pass++;
                if (!e.dma) begin
                    n_checks++; if (dma_din !== last_dma)
                        $display("FAIL b2b_dma_hold%0d: got %h want %h", acks, dma_din, last_dma); else n_pass++;
                end else begin
                    last_dma = e.data;
                end
                prev = cyc;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; dma_req = 1'b0;
        n_checks++; if (acks !== 4) $display("FAIL b2b_timeout: got %0d acks want 4", acks); else n_pass++;
        n_checks++; if (n_overlap !== 0) $display("FAIL overlap: got %0d want 0", n_overlap); else n_pass++;
        sb_q.delete();
    endtask

    task automatic test_reset_mid;
        int g, a, c0; logic [7:0] d; logic got, seen; exp_t e;
        ext_din = 8'h66;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h4000;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ext_rd) seen = 1'b1;
        end
        n_checks++; if (!seen) $display("FAIL mid_rst_timeout: got no ext_rd want ext_rd"); else n_pass++;
        c0 = n_cpu_ack;
        #1 reset = 1'b1;
        #1;
        n_checks++; if (ext_rd !== 1'b0 || cpu_ack !== 1'b0 || cpu_din !== 8'hFF)
            $display("FAIL mid_rst_drop: got rd %b ack %b din %h want 0 0 ff", ext_rd, cpu_ack, cpu_din);
        else n_pass++;
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        n_checks++; if (n_cpu_ack - c0 !== 0) $display("FAIL mid_rst_no_ack: got %0d want 0", n_cpu_ack - c0); else n_pass++;
        ext_din = 8'h77;
        sb_q.push_back('{dma: 1'b0, data: 8'h77});
        do_access(1'b0, 1'b0, 16'h4000, 8'h00, g, a, d, got);
        e = sb_q.pop_front();
        n_checks++; if (!got) $display("FAIL mid_rst_retry_timeout: got no ack want ack");
        else if (d !== e.data || a - g !== 3 + W)
            $display("FAIL mid_rst_retry: got %h lat %0d want %h lat %0d", d, a - g, e.data, 3 + W);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = 16'h0; cpu_dout = 8'h0;
        dma_req = 1'b0; dma_adr = 16'h0;
        rom_hide = 1'b0; ext_din = 8'h00;
        test_reset();
        test_rom_read();
        test_reg_write();
        test_ext();
        test_dma();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gb_bootbus_ctrl.md
Name: gb_bootbus_ctrl

Overview:
Bus sequencer in front of the boot ROM and the external cartridge bus. It arbitrates between CPU and OAM-DMA requesters and decodes each access to boot ROM, hide register or external bus. It generates the boot ROM's edge-sensitive read strobe and register-write pulse in a fixed multi-cycle sequence, then returns data with a one-cycle ack. It sits between the CPU/DMA units and gb_bootrom plus the cartridge pins.

Parameters:
EXT_WAIT, 1, extra strobe cycles held on ext_rd/ext_wr (0..7)
HIDE_ADR, 16'hFF50, address of boot ROM hide register

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req
cpu_adr  in  16  CPU address
cpu_dout  in  8  CPU write data
cpu_din  out  8  read data to CPU, valid during cpu_ack
cpu_ack  out  1  one-cycle completion pulse
dma_req  in  1  DMA read request, level, held until dma_ack
dma_adr  in  16  DMA source address
dma_din  out  8  read data to DMA, valid during dma_ack
dma_ack  out  1  one-cycle completion pulse
rom_adr  out  8  boot ROM address
rom_read  out  1  boot ROM read strobe; ROM latches on rising edge
rom_write_reg  out  1  hide-register write pulse
rom_dout  in  8  boot ROM data
rom_hide  in  1  1=boot ROM unmapped
ext_adr  out  16  cartridge address
ext_dout  out  8  cartridge write data
ext_rd  out  1  cartridge read strobe
ext_wr  out  1  cartridge write strobe
ext_din  in  8  cartridge read data

Behaviour:
- All outputs registered. Async reset: FSM=IDLE; all strobes/acks=0; adr outputs=0; ext_dout=0; cpu_din=dma_din=8'hFF; last_grant=DMA.
- Decode of granted access:
  - ROM: read with adr[15:8]==0 and rom_hide==0.
  - REG: adr==HIDE_ADR. Write -> rom_write_reg; read returns 8'hFF.
  - EXT: everything else, including all writes to 0x0000-0x00FF.
  - DMA is read-only.
- Arbitration in IDLE only: one requester -> grant it. Both -> the one not in last_grant (round-robin); update last_grant on grant. Request, address, we, data latched at grant; later input changes are ignored until ack.
- FSM: IDLE -> SETUP -> STROBE -> [WAIT] -> DONE -> IDLE.
  - SETUP (1 cycle): rom_adr/ext_adr/ext_dout driven; no strobes.
  - STROBE: ROM -> rom_read=1 for exactly 1 cycle. REG write -> rom_write_reg=1 for 1 cycle. REG read -> no strobe. EXT -> ext_rd or ext_wr=1 for 1+EXT_WAIT cycles (STROBE plus WAIT, counter counts EXT_WAIT down).
  - Read data (rom_dout or ext_din) sampled at the clock edge ending the last strobe cycle.
  - DONE: strobes=0; granted ack=1 for 1 cycle; granted din=captured data. Other din holds its value.
- Latency from grant cycle to ack: 3 cycles for ROM/REG; 3+EXT_WAIT for EXT. Throughput: one access per 4 (4+EXT_WAIT) cycles.
- Addresses held after DONE until next grant. rom_read and ext_rd/ext_wr never both high.
- Back-to-back: req still high in the IDLE cycle after ack is a new request.
- rom_hide is sampled at grant. A change mid-access does not reroute it.
- Reset mid-access: strobes drop asynchronously; no ack; the access is lost; the requester re-issues.
- Req dropped before ack: protocol violation; the access completes and is acked anyway.

Test Plan:
- Reset, hide=0, CPU read 0x0005, ROM[5]=0x31 -> rom_adr=0x05; rom_read high cycle 2 only; cpu_ack cycle 3 with cpu_din=0x31; ext_rd never high.
- CPU write 0xFF50 data 0x01 -> rom_write_reg single pulse cycle 2; ext_wr=0; ack cycle 3. Then hide=1, read 0x0005 -> ext_adr=0x0005, ext_rd, no rom_read.
- EXT_WAIT=2, CPU read 0x4000, ext_din=0xA5 -> ext_rd high cycles 2-4; cpu_ack cycle 5 with 0xA5. CPU write 0x2000=0x03 -> ext_wr 3 cycles, ext_dout=0x03.
- cpu_req and dma_req both rise after reset, both held -> CPU granted first, then DMA, alternating; no ack overlap; dma_din unchanged on CPU acks.
- DMA read 0x0010 with hide=0 -> rom path, dma_ack with ROM[0x10]. DMA read 0xFF50 -> dma_din=0xFF, no strobes.
- Reset asserted during EXT STROBE -> ext_rd=0 immediately; no ack; din=0xFF. After release, a new CPU read completes normally.
